// File: rtl/control_store_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : control_store_pkg
//  Description : Shared definitions for the parametrised microcode control
//                store: default geometry, loader FSM state encoding and the
//                even-parity helper used on the write and fetch paths.
//  Revision    : 1.0 - initial release
// ============================================================================
package control_store_pkg;

  // Default geometry matches the classic Mic-1 512 x 36 control store.
  localparam int CS_WIDTH = 36;
  localparam int CS_DEPTH = 512;

  // Widest word the parity helper accepts; callers zero-extend into it,
  // which does not change the XOR reduction.
  localparam int PARITY_MAX_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_store_ram.sv
`default_nettype none
// ============================================================================
//  Module      : control_store_ram
//  Description : Simple dual-port storage array, one synchronous write port
//                and one registered read port. The read register holds its
//                value whenever re is low. Array contents are not reset.
//  Ports       : clk, rst          - clock, async active-high reset (read reg)
//                we, waddr, wdata  - write port
//                re, raddr, rdata  - registered read port
//  Revision    : 1.0 - initial release
// ============================================================================
module control_store_ram
  import control_store_pkg::*;
#(
  parameter int DW    = CS_WIDTH,
  parameter int DEPTH = CS_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Callers guarantee both addresses are in range when we/re are asserted.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/control_store_loader.sv
`default_nettype none
// ============================================================================
//  Module      : control_store_loader
//  Description : Parametrised microcode control store with a registered
//                fetch port (valid flag, write-first bypass), a direct
//                single-word write port and a streaming burst loader
//                (base/count, valid/ready handshake).
//  Ports       : clk, rst                      - clock, async active-high reset
//                wen, waddr, wdata             - direct write (IDLE only)
//                ren, raddr, rdata, rvalid     - fetch, one-cycle latency
//                ld_start, ld_base, ld_count   - burst load command
//                ld_valid, ld_data, ld_ready   - burst data handshake
//                ld_busy, ld_done              - loader status
//                addr_err, par_err             - error pulses
//  Options     : CONTROL_STORE_PARITY_EN - store an even-parity bit per word
//                and check it on fetch; otherwise par_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_store_loader
  import control_store_pkg::*;
#(
  parameter int WIDTH = CS_WIDTH,
  parameter int DEPTH = CS_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  input  logic             ld_start,
  input  logic [AW-1:0]    ld_base,
  input  logic [AW:0]      ld_count,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  output logic             ld_busy,
  output logic             ld_done,
  output logic             addr_err,
  output logic             par_err
);

`ifdef CONTROL_STORE_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int              MW       = WIDTH + PB;
  localparam int              AW1      = AW + 1;
  localparam logic [AW:0]     DEPTH_W  = AW1'(DEPTH);
  localparam logic [AW-1:0]   LAST_PTR = AW'(DEPTH - 1);

  ld_state_e        state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW:0]      rem_q, rem_d;
  logic             zero_done_q, zero_done_d;
  logic             rvalid_q, rvalid_d;
  logic             byp_q, byp_d;
  logic [WIDTH-1:0] byp_data_q, byp_data_d;
  logic             oor_q, oor_d;
  logic             addr_err_q, addr_err_d;

  logic             idle;
  logic             raddr_oor;
  logic             waddr_oor;
  logic             rd_fire;
  logic             wr_direct;
  logic             wr_load;
  logic             bypass_hit;
  logic             ram_we;
  logic             ram_re;
  logic [AW-1:0]    ram_waddr;
  logic [WIDTH-1:0] wr_data_sel;
  logic [MW-1:0]    ram_wdata;
  logic [MW-1:0]    ram_rdata;

  // --------------------------------------------------------------------------
  // Access qualification
  // --------------------------------------------------------------------------
  assign idle       = (state_q == ST_IDLE);
  // Only reachable when DEPTH is not a power of two.
  assign raddr_oor  = ({1'b0, raddr} >= DEPTH_W);
  assign waddr_oor  = ({1'b0, waddr} >= DEPTH_W);
  assign rd_fire    = idle && ren;
  assign wr_direct  = idle && wen && !waddr_oor;
  assign wr_load    = (state_q == ST_LOAD) && ld_valid;
  assign bypass_hit = wr_direct && (waddr == raddr);

  // Direct and load writes never overlap: direct writes are IDLE-only.
  assign ram_we      = wr_direct || wr_load;
  assign ram_waddr   = wr_load ? ptr_q : waddr;
  assign wr_data_sel = wr_load ? ld_data : wdata;
  // Bypassed and out-of-range reads do not touch the array, so the array's
  // read register keeps its last value and the output mux supplies the word.
  assign ram_re      = rd_fire && !raddr_oor && !bypass_hit;

`ifdef CONTROL_STORE_PARITY_EN
  assign ram_wdata = {even_parity(PARITY_MAX_W'(wr_data_sel)), wr_data_sel};
`else
  assign ram_wdata = wr_data_sel;
`endif

  control_store_ram #(
    .DW    (MW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  // --------------------------------------------------------------------------
  // Loader FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    zero_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ld_start) begin
          if (ld_count != '0) begin
            ptr_d   = ld_base;
            rem_d   = ld_count;
            state_d = ST_LOAD;
          end else begin
            // Empty burst: report completion without leaving IDLE.
            zero_done_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          ptr_d = (ptr_q == LAST_PTR) ? '0 : ptr_q + AW'(1);
          rem_d = rem_q - AW1'(1);
          if (rem_q == AW1'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Fetch bookkeeping: selectors only change on an accepted fetch so that
  // rdata holds between fetches.
  // --------------------------------------------------------------------------
  always_comb begin
    rvalid_d   = rd_fire;
    byp_d      = byp_q;
    oor_d      = oor_q;
    byp_data_d = byp_data_q;
    if (rd_fire) begin
      oor_d      = raddr_oor;
      byp_d      = bypass_hit;
      byp_data_d = wdata;
    end
    addr_err_d = idle && ((ren && raddr_oor) || (wen && waddr_oor));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      zero_done_q <= 1'b0;
      rvalid_q    <= 1'b0;
      byp_q       <= 1'b0;
      byp_data_q  <= '0;
      oor_q       <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      zero_done_q <= zero_done_d;
      rvalid_q    <= rvalid_d;
      byp_q       <= byp_d;
      byp_data_q  <= byp_data_d;
      oor_q       <= oor_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rdata    = oor_q ? '0 : (byp_q ? byp_data_q : ram_rdata[WIDTH-1:0]);
  assign rvalid   = rvalid_q;
  assign ld_ready = (state_q == ST_LOAD);
  assign ld_busy  = (state_q != ST_IDLE);
  assign ld_done  = (state_q == ST_DONE) || zero_done_q;
  assign addr_err = addr_err_q;

`ifdef CONTROL_STORE_PARITY_EN
  // Bypassed and out-of-range reads carry no stored parity to check.
  assign par_err = rvalid_q && !oor_q && !byp_q &&
                   (even_parity(PARITY_MAX_W'(ram_rdata[WIDTH-1:0])) != ram_rdata[WIDTH]);
`else
  assign par_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/control_store_loader.md
Name: control_store_loader

Overview:
- Parametrised successor to the fixed 512x36 Mic-1 control store.
- Adds a registered fetch port with a valid flag and write-first bypass.
- Adds a streaming microcode loader (base, count, valid/ready handshake) so microprograms load in bursts rather than word-by-word.
- Sits between the MPC/MIR logic (fetch side) and the microcode boot/debug loader (load side).

Parameters:
- WIDTH, 36, microinstruction width in bits.
- DEPTH, 512, number of words; need not be a power of two.
- AW, $clog2(DEPTH), address width, derived; do not override.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- wen  in  1  direct single-word write enable
- waddr  in  AW  direct write address
- wdata  in  WIDTH  direct write data
- ren  in  1  fetch request
- raddr  in  AW  fetch address (MPC)
- rdata  out  WIDTH  fetched microinstruction (registered)
- rvalid  out  1  rdata updated this cycle
- ld_start  in  1  begin burst load
- ld_base  in  AW  first load address
- ld_count  in  AW+1  number of words to load
- ld_valid  in  1  ld_data valid
- ld_data  in  WIDTH  load word
- ld_ready  out  1  loader accepts ld_data
- ld_busy  out  1  FSM not IDLE
- ld_done  out  1  one-cycle pulse, burst complete
- addr_err  out  1  one-cycle pulse, out-of-range access
- par_err  out  1  one-cycle pulse, parity mismatch (tied 0 without macro)

Behaviour:
- Reset (async, any state): rdata=0, rvalid=0, ld_ready=0, ld_busy=0, ld_done=0, addr_err=0, par_err=0, FSM=IDLE. Memory contents are not reset.
- Reset mid-load: FSM returns to IDLE immediately. Words already written stay; remaining words are untouched.
- FSM states:
  - IDLE: on ld_start with ld_count>0, latch ptr=ld_base and rem=ld_count, go to LOAD. On ld_start with ld_count==0, pulse ld_done next cycle and stay IDLE.
  - LOAD: ld_ready=1. Each cycle with ld_valid&&ld_ready, write ld_data to mem[ptr], ptr=(ptr==DEPTH-1)?0:ptr+1, rem-=1. When the beat with rem==1 is accepted, go to DONE. ld_start is ignored.
  - DONE: one cycle. ld_done=1, ld_ready=0. Then go to IDLE.
- ld_busy=1 in LOAD and DONE.
- Fetch:
  - In IDLE with ren=1: at the next edge, rdata=mem[raddr] and rvalid=1. Latency is one cycle.
  - With ren=0, or while ld_busy: rvalid=0 and rdata holds its value.
- Direct write: in IDLE, wen=1 writes wdata to mem[waddr] at the edge. wen is ignored while ld_busy.
- Same-cycle wen&&ren to the same address: rdata=wdata (write-first).
- Address >= DEPTH (only possible when DEPTH is not a power of two):
  - Write is dropped.
  - Read returns rdata=0 with rvalid=1.
  - addr_err pulses in the cycle after the access.
  - Load pointer never goes out of range because it wraps at DEPTH-1.

Optional Feature:
- Macro CONTROL_STORE_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit computed on write (direct and load).
  - On fetch, parity is recomputed. A mismatch raises par_err in the same cycle as rvalid.
  - rdata is still delivered unchanged.
  - Bypassed reads always carry fresh parity, so no error.
- Undefined: no parity storage; par_err tied 0.

Decomposition:
- Shared package control_store_pkg:
  - default WIDTH/DEPTH localparams
  - FSM state enum typedef (IDLE, LOAD, DONE)
  - parity function
- One sub-module: control_store_ram.
  - Simple dual-port array (one write, one registered read), WIDTH+parity bits wide.
  - The top module muxes the direct and load write sources onto its single write port.

Test Plan:
- wen, waddr=3, wdata=41; next cycle ren, raddr=3 -> one cycle later rdata=41, rvalid=1 for exactly one cycle.
- Same cycle: wen and ren, address 5, wdata=0xABC -> next cycle rdata=0xABC.
- ld_start, ld_base=510, ld_count=4, data 1,2,3,4 with one ld_valid gap -> mem[510]=1, mem[511]=2, mem[0]=3, mem[1]=4; ld_done pulses once, one cycle after the 4th beat; read-back matches.
- During LOAD: ren to address 0 -> rvalid=0. wen to address 7 with 0x55 -> mem[7] unchanged after load.
- DEPTH=500: ren with raddr=505 -> rdata=0, addr_err pulse. wen to address 505 -> no array change.
- rst asserted after 2 of 4 load beats -> ld_busy=0 and ld_ready=0 immediately; first 2 words written, next 2 unchanged. With PARITY_EN, force a stored parity flip -> par_err=1 alongside rvalid.
